// File: rtl/deserializer.sv
// Serial-to-parallel deserializer: gathers a valid-qualified 1-bit stream, MSB first, into DATA_W-bit words.
// Optional `DESER_FLUSH_EN emits a partial word, MSB-aligned, after FLUSH_TIMEOUT idle cycles.
module deserializer #(
  parameter int DATA_W        = 16,
  parameter int CNT_W         = $clog2(DATA_W + 1),
  parameter int FLUSH_TIMEOUT = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              data_i,
  input  logic              data_val_i,
  output logic [DATA_W-1:0] deser_data_o,
  output logic [CNT_W-1:0]  deser_mod_o,
  output logic              deser_data_val_o,
  output logic              deser_busy_o
);

  if (DATA_W < 2)        begin : g_bad_width   $error("DATA_W must be >= 2");        end
  if (FLUSH_TIMEOUT < 1) begin : g_bad_timeout $error("FLUSH_TIMEOUT must be >= 1"); end

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q;
  logic              val_q, busy_q;
  logic              emit;
  logic [DATA_W-1:0] emit_word;
  logic [CNT_W-1:0]  shamt;
  logic [DATA_W-1:0] with_bit;

  // Bits are placed straight into their final MSB-first slot, so a flushed
  // partial word is already aligned with its unused LSBs at zero.
  assign shamt    = CNT_W'(DATA_W - 1) - cnt_q;
  assign with_bit = shift_q | ({{(DATA_W-1){1'b0}}, data_i} << shamt);

`ifdef DESER_FLUSH_EN
  localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [CNT_W-1:0]  mod_q, emit_mod;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    emit      = 1'b0;
    emit_word = shift_q;
`ifdef DESER_FLUSH_EN
    emit_mod  = '0;
    idle_d    = idle_q;
`endif
    if (data_val_i) begin
      if (cnt_q == CNT_W'(DATA_W - 1)) begin
        emit      = 1'b1;
        emit_word = with_bit;
        cnt_d     = '0;
        shift_d   = '0;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        shift_d = with_bit;
      end
    end
`ifdef DESER_FLUSH_EN
    // A valid bit always beats an expiring timeout.
    if (data_val_i || cnt_q == '0) begin
      idle_d = '0;
    end else if (idle_q == IDLE_W'(FLUSH_TIMEOUT - 1)) begin
      emit      = 1'b1;
      emit_word = shift_q;
      emit_mod  = cnt_q;
      cnt_d     = '0;
      shift_d   = '0;
      idle_d    = '0;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      val_q   <= emit;
      busy_q  <= (cnt_d != '0);
      if (emit) data_q <= emit_word;
    end
  end

`ifdef DESER_FLUSH_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_q <= '0;
      mod_q  <= '0;
    end else begin
      idle_q <= idle_d;
      if (emit) mod_q <= emit_mod;
    end
  end
  assign deser_mod_o = mod_q;
`else
  assign deser_mod_o = '0;
`endif

  assign deser_data_o     = data_q;
  assign deser_data_val_o = val_q;
  assign deser_busy_o     = busy_q;

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: scoreboard of expected {word, mod} popped on each valid pulse.
// Covers the default build and, when compiled with +define+DESER_FLUSH_EN, the idle flush path.
module tb_deserializer;

  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(DATA_W + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              data_i = 1'b0;
  logic              data_val_i = 1'b0;
  logic [DATA_W-1:0] deser_data_o;
  logic [CNT_W-1:0]  deser_mod_o;
  logic              deser_data_val_o;
  logic              deser_busy_o;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cycle     = 0;

  logic [DATA_W+CNT_W-1:0] exp_q[$];
  int                      pulse_cycles[$];

  deserializer #(.DATA_W(DATA_W), .FLUSH_TIMEOUT(8)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .data_i           (data_i),
    .data_val_i       (data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_mod_o      (deser_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .deser_busy_o     (deser_busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (deser_data_val_o === 1'b1) begin
      logic [DATA_W+CNT_W-1:0] exp;
      pulse_cycles.push_back(cycle);
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse: got data=%h mod=%0d, expected no pulse", deser_data_o, deser_mod_o);
      end else begin
        exp = exp_q.pop_front();
        if ({deser_data_o, deser_mod_o} !== exp)
          $display("FAIL word: got data=%h mod=%0d, expected data=%h mod=%0d",
                   deser_data_o, deser_mod_o, exp[DATA_W+CNT_W-1:CNT_W], exp[CNT_W-1:0]);
        else pass_cnt++;
      end
    end
  end

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] want);
    total_cnt++;
    if (got !== want) $display("FAIL %s: got %0h, expected %0h", name, got, want);
    else pass_cnt++;
  endtask

  task automatic send_bit(input logic b);
    data_i     = b;
    data_val_i = 1'b1;
    @(posedge clk); #1;
    data_val_i = 1'b0;
  endtask

  task automatic idle(input int n);
    data_val_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w, input int gap);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      send_bit(w[i]);
      if (gap > 0 && i > 0) idle(gap);
    end
  endtask

  task automatic drained(input string name);
    expect_val(name, exp_q.size(), 0);
  endtask

  task automatic test_reset;
    #3;
    expect_val("rst_data", deser_data_o, 0);
    expect_val("rst_mod", deser_mod_o, 0);
    expect_val("rst_val", deser_data_val_o, 0);
    expect_val("rst_busy", deser_busy_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    expect_val("rst_busy_after", deser_busy_o, 0);
  endtask

  task automatic test_full_word;
    exp_q.push_back({16'hA5C3, 5'd0});
    send_word(16'hA5C3, 0);
    expect_val("full_val_latency", deser_data_val_o, 1);
    expect_val("full_busy_in_pulse", deser_busy_o, 0);
    idle(1);
    expect_val("full_val_one_cycle", deser_data_val_o, 0);
    expect_val("full_data_hold", deser_data_o, 16'hA5C3);
    idle(2);
    drained("full_drained");
  endtask

  task automatic test_gapped;
    int n0;
    n0 = pulse_cycles.size();
    exp_q.push_back({16'hA5C3, 5'd0});
    send_bit(1'b1);
    idle(3);
    expect_val("gap_busy_mid", deser_busy_o, 1);
    expect_val("gap_no_early_pulse", deser_data_val_o, 0);
    for (int i = DATA_W - 2; i >= 0; i--) begin
      logic [DATA_W-1:0] w;
      w = 16'hA5C3;
      send_bit(w[i]);
      if (i > 0) idle(3);
    end
    expect_val("gap_val_latency", deser_data_val_o, 1);
    idle(3);
    expect_val("gap_single_pulse", pulse_cycles.size() - n0, 1);
    drained("gap_drained");
  endtask

  task automatic test_back_to_back;
    pulse_cycles.delete();
    exp_q.push_back({16'hFFFF, 5'd0});
    exp_q.push_back({16'h0001, 5'd0});
    send_word(16'hFFFF, 0);
    send_word(16'h0001, 0);
    idle(2);
    expect_val("b2b_pulse_count", pulse_cycles.size(), 2);
    if (pulse_cycles.size() == 2)
      expect_val("b2b_spacing", pulse_cycles[1] - pulse_cycles[0], 16);
    drained("b2b_drained");
  endtask

  task automatic test_partial;
    int n0;
    logic [4:0] bits;
    bits = 5'b10110;
    n0 = pulse_cycles.size();
`ifdef DESER_FLUSH_EN
    exp_q.push_back({16'hB000, 5'd5});
`endif
    for (int i = 4; i >= 0; i--) send_bit(bits[i]);
    idle(7);
    expect_val("partial_no_pulse_7", deser_data_val_o, 0);
    expect_val("partial_busy_7", deser_busy_o, 1);
    idle(1);
`ifdef DESER_FLUSH_EN
    expect_val("flush_pulse", deser_data_val_o, 1);
    expect_val("flush_busy_drop", deser_busy_o, 0);
    idle(2);
    expect_val("flush_pulse_count", pulse_cycles.size() - n0, 1);
`else
    expect_val("hold_no_pulse", deser_data_val_o, 0);
    expect_val("hold_busy", deser_busy_o, 1);
    exp_q.push_back({16'hB000, 5'd0});
    for (int i = 0; i < 11; i++) send_bit(1'b0);
    expect_val("hold_complete_pulse", deser_data_val_o, 1);
    idle(2);
    expect_val("hold_pulse_count", pulse_cycles.size() - n0, 1);
`endif
    drained("partial_drained");
  endtask

  task automatic test_reset_mid_word;
    int n0;
    n0 = pulse_cycles.size();
    for (int i = 0; i < 7; i++) send_bit(i[0]);
    expect_val("mid_busy_before", deser_busy_o, 1);
    expect_val("mid_data_before", deser_data_o, 16'hB000);
    #2 rst_n = 1'b0;
    #1;
    expect_val("async_data", deser_data_o, 0);
    expect_val("async_mod", deser_mod_o, 0);
    expect_val("async_val", deser_data_val_o, 0);
    expect_val("async_busy", deser_busy_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    expect_val("mid_busy_after", deser_busy_o, 0);
    exp_q.push_back({16'h1234, 5'd0});
    send_word(16'h1234, 0);
    idle(3);
    expect_val("mid_single_pulse", pulse_cycles.size() - n0, 1);
    drained("mid_drained");
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_gapped();
    test_back_to_back();
    test_partial();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
